quad_encoder_gen: RTL

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

---
 rtl/quad_encoder_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator: emits Gray-coded (a,b) detent sequences
// on command, one phase per en strobe, and tracks the emitted detent position.
module quad_encoder_gen #(
    parameter int w       = 16,
    parameter int steps_w = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [steps_w-1:0] cmd_steps,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done,
    output logic [w-1:0]       position
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [w-1:0]       pos_one  = {{(w-1){1'b0}}, 1'b1};
    localparam logic [steps_w-1:0] step_one = {{(steps_w-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_next;
    logic               dir_q;
    logic [steps_w-1:0] remaining;
    logic [1:0]         phase_next;
    logic               accept;
    logic               step;
    logic               detent_end;
    logic               last_detent;

    assign cmd_ready = (state == IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;
    assign step      = (state == RUN) & en;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        phase_next = {a, b};
        case ({a, b})
            2'b00:   phase_next = dir_q ? 2'b01 : 2'b10;
            2'b01:   phase_next = dir_q ? 2'b11 : 2'b00;
            2'b11:   phase_next = dir_q ? 2'b10 : 2'b01;
            default: phase_next = dir_q ? 2'b00 : 2'b11;
        endcase
    end

    // Returning to phase 00 is always the fourth transition of a detent.
    assign detent_end  = step & (phase_next == 2'b00);
    assign last_detent = detent_end & (remaining == step_one);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (cmd_steps != '0)) state_next = RUN;
            RUN:     if (last_detent) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a         <= 1'b0;
            b         <= 1'b0;
            dir_q     <= 1'b0;
            remaining <= '0;
            position  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (accept && (cmd_steps == '0)) || last_detent;
            if (accept) begin
                dir_q     <= cmd_dir;
                remaining <= cmd_steps;
            end
            if (step) begin
                {a, b} <= phase_next;
            end
            if (detent_end) begin
                position  <= dir_q ? position + pos_one : position - pos_one;
                remaining <= remaining - step_one;
            end
        end
    end

endmodule
